// File: rtl/vga_pkg.sv
// Shared VGA definitions.
// Carries screen timing constants, the start-text bitmap size, the blink state
// type and the packed timing/colour bus that travels down the pixel pipeline.
package vga_pkg;

    // 1024x768 @ 60 Hz timing
    localparam int unsigned HOR_ACTIVE = 1024;
    localparam int unsigned HOR_TOTAL  = 1344;
    localparam int unsigned VER_ACTIVE = 768;
    localparam int unsigned VER_TOTAL  = 806;

    // "press start" text bitmap
    localparam int unsigned START_W = 400;
    localparam int unsigned START_H = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HIDE = 2'd2
    } blink_state_e;

    // Timing signals plus pixel colour; 38 bits wide.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

endpackage

// File: rtl/vga_delay.sv
// N-stage register chain for the VGA timing/colour bus.
// Ports:
//   clk     - pixel clock
//   rst_n   - synchronous active-low clear of every stage
//   data_i  - bus entering the chain
//   data_o  - bus delayed by N clocks
module vga_delay #(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned N      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] pipe_d [N];
    logic [DATA_W-1:0] pipe_q [N];

    always_comb begin
        pipe_d[0] = data_i;
        for (int i = 1; i < N; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign data_o = pipe_q[N-1];

endmodule

// File: rtl/draw_start_screen.sv
// Overlays the blinking "press start" bitmap onto the VGA pixel stream.
// Ports:
//   clk, rst_n            - pixel clock, synchronous active-low reset
//   enable                - game is in its start state
//   hcount_in..rgb_in     - upstream pixel coordinates, timing and colour
//   rom_addr / rom_pixel  - start-text ROM address out, data back one clock later
//   hcount_out..rgb_out   - same bus three clocks later with the text composited
module draw_start_screen
    import vga_pkg::*;
#(
    parameter int unsigned X_POS        = 112,
    parameter int unsigned Y_POS        = 200,
    parameter int unsigned WIDTH        = START_W,
    parameter int unsigned HEIGHT       = START_H,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] KEY_COLOR    = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [14:0] rom_addr,
    input  logic [11:0] rom_pixel,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0]      X_LO     = 11'(X_POS);
    localparam logic [10:0]      X_HI     = 11'(X_POS + WIDTH);
    localparam logic [10:0]      Y_LO     = 11'(Y_POS);
    localparam logic [10:0]      Y_HI     = 11'(Y_POS + HEIGHT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic         in_box;
    logic [10:0]  dx;
    logic [10:0]  dy;
    logic [15:0]  addr_full;
    logic         frame_tick;

    logic [14:0]  rom_addr_d, rom_addr_q;
    logic         vblnk_prev_d, vblnk_prev_q;
    blink_state_e state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic         in_box1_d, in_box1_q;
    logic         vis1_d, vis1_q;
    logic         in_box2_d, in_box2_q;
    logic         vis2_d, vis2_q;
    vga_bus_t     bus_in, bus2;
    vga_bus_t     out_d, out_q;

    // Box test is done on raw coordinates so nothing outside the box can wrap in.
    always_comb begin
        in_box = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                 (vcount_in >= Y_LO) && (vcount_in < Y_HI) &&
                 !hblnk_in && !vblnk_in;
        dx         = hcount_in - X_LO;
        dy         = vcount_in - Y_LO;
        addr_full  = 16'(dy) * 16'(WIDTH) + 16'(dx);
        rom_addr_d = in_box ? addr_full[14:0] : '0;
    end

    // Frame tick on the rising edge of vertical blanking.
    assign vblnk_prev_d = vblnk_in;
    assign frame_tick   = vblnk_in && !vblnk_prev_q;

    // Blink FSM; only moves on a frame tick so a frame is never torn.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end
                end
                SHOW, HIDE: begin
                    if (!enable) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = (state_q == SHOW) ? HIDE : SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stage 1 captures the pre-update state, so a tick never affects its own pixel.
    always_comb begin
        in_box1_d = in_box;
        vis1_d    = (state_q == SHOW);
        in_box2_d = in_box1_q;
        vis2_d    = vis1_q;
    end

    always_comb begin
        bus_in.hcount = hcount_in;
        bus_in.vcount = vcount_in;
        bus_in.hsync  = hsync_in;
        bus_in.vsync  = vsync_in;
        bus_in.hblnk  = hblnk_in;
        bus_in.vblnk  = vblnk_in;
        bus_in.rgb    = rgb_in;
    end

    // Stages 1 and 2: bus arrives at stage 2 alongside rom_pixel.
    vga_delay #(
        .DATA_W ($bits(vga_bus_t)),
        .N      (2)
    ) u_bus_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (bus_in),
        .data_o (bus2)
    );

    // Stage 3 composite: key colour lets the background through.
    always_comb begin
        out_d = bus2;
        if (in_box2_q && vis2_q && (rom_pixel != KEY_COLOR)) begin
            out_d.rgb = rom_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr_q   <= '0;
            vblnk_prev_q <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            in_box1_q    <= 1'b0;
            vis1_q       <= 1'b0;
            in_box2_q    <= 1'b0;
            vis2_q       <= 1'b0;
            out_q        <= '0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            vblnk_prev_q <= vblnk_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_box1_q    <= in_box1_d;
            vis1_q       <= vis1_d;
            in_box2_q    <= in_box2_d;
            vis2_q       <= vis2_d;
            out_q        <= out_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_start_screen.sv
// Scoreboard bench for draw_start_screen: a driver applies directed and random
// pixels, a frame-counting reference model predicts each output and queues it,
// and a monitor pops and compares when the prediction falls due.
module tb_draw_start_screen;
    import vga_pkg::*;

    localparam int          XP    = 112;
    localparam int          YP    = 200;
    localparam int          BW    = 400;
    localparam int          BH    = 48;
    localparam int          BLINK = 30;
    localparam logic [11:0] KEY   = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [14:0] rom_addr;
    logic [11:0] rom_pixel;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    draw_start_screen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .rom_addr   (rom_addr),
        .rom_pixel  (rom_pixel),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // ROM contents: addr 5 is green, addr 6 and every addr%7==3 are transparent.
    function automatic logic [11:0] rom_fn(input logic [14:0] a);
        int ai;
        ai = int'(a);
        if (ai == 5) return 12'h0A0;
        if (ai == 6) return KEY;
        if (ai % 7 == 3) return KEY;
        return 12'(ai * 37) ^ 12'h5A3;
    endfunction

    always @(posedge clk) rom_pixel <= rom_fn(rom_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       due;
        vga_bus_t bus;
    } out_exp_t;

    typedef struct {
        int          due;
        logic [14:0] addr;
    } addr_exp_t;

    out_exp_t  out_q[$];
    addr_exp_t addr_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: frames elapsed since the text was switched on.
    bit m_active  = 1'b0;
    int m_frames  = 0;
    bit m_prev_vb = 1'b0;

    task automatic drive(input bit rst, input bit en, input int h, input int v,
                         input bit hb, input bit vb, input logic [11:0] rgb);
        int        s;
        bit        box;
        bit        vis;
        int        addr;
        logic [11:0] pix;
        out_exp_t  oe;
        addr_exp_t ae;
        @(posedge clk);
        #1;
        s         = cyc + 1;
        rst_n     = rst;
        enable    = en;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        if (!rst) begin
            // Reset flushes whatever was still in flight.
            while (out_q.size() > 0 && out_q[$].due >= s) void'(out_q.pop_back());
            while (addr_q.size() > 0 && addr_q[$].due >= s) void'(addr_q.pop_back());
            oe.due = s;
            oe.bus = '0;
            out_q.push_back(oe);
            ae.due  = s;
            ae.addr = '0;
            addr_q.push_back(ae);
            m_active  = 1'b0;
            m_frames  = 0;
            m_prev_vb = 1'b0;
        end else begin
            box  = (h >= XP) && (h < XP + BW) && (v >= YP) && (v < YP + BH) && !hb && !vb;
            addr = box ? (v - YP) * BW + (h - XP) : 0;
            vis  = m_active && ((m_frames / BLINK) % 2 == 0);
            pix  = rom_fn(15'(addr));
            oe.due        = s + 2;
            oe.bus.hcount = 11'(h);
            oe.bus.vcount = 11'(v);
            oe.bus.hsync  = hsync_in;
            oe.bus.vsync  = vsync_in;
            oe.bus.hblnk  = hb;
            oe.bus.vblnk  = vb;
            oe.bus.rgb    = (box && vis && pix != KEY) ? pix : rgb;
            out_q.push_back(oe);
            ae.due  = s;
            ae.addr = 15'(addr);
            addr_q.push_back(ae);
            if (vb && !m_prev_vb) begin
                if (!m_active) begin
                    if (en) begin
                        m_active = 1'b1;
                        m_frames = 0;
                    end
                end else if (!en) begin
                    m_active = 1'b0;
                end else begin
                    m_frames++;
                end
            end
            m_prev_vb = vb;
        end
    endtask

    task automatic rand_pixel(input bit en);
        drive(1'b1, en, $urandom_range(105, 520), $urandom_range(195, 252),
              ($urandom_range(0, 7) == 0), 1'b0, 12'($urandom));
    endtask

    // Monitor
    initial begin
        out_exp_t    oe;
        addr_exp_t   ae;
        logic [25:0] act_t, exp_t;
        forever begin
            @(negedge clk);
            if (out_q.size() > 0 && out_q[0].due <= cyc) begin
                oe    = out_q.pop_front();
                act_t = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out};
                exp_t = {oe.bus.hcount, oe.bus.vcount, oe.bus.hsync, oe.bus.vsync,
                         oe.bus.hblnk, oe.bus.vblnk};
                total++;
                if (oe.due != cyc || act_t !== exp_t) begin
                    bad++;
                    $display("FAIL timing cyc=%0d due=%0d got=%h want=%h",
                             cyc, oe.due, act_t, exp_t);
                end
                total++;
                if (rgb_out !== oe.bus.rgb) begin
                    bad++;
                    $display("FAIL rgb cyc=%0d got=%h want=%h", cyc, rgb_out, oe.bus.rgb);
                end
            end
            if (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
                ae = addr_q.pop_front();
                total++;
                if (ae.due != cyc || rom_addr !== ae.addr) begin
                    bad++;
                    $display("FAIL rom_addr cyc=%0d got=%0d want=%0d", cyc, rom_addr, ae.addr);
                end
            end
        end
    end

    // Driver
    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = '0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom), $urandom_range(0, 1343), $urandom_range(0, 805),
                  1'($urandom), 1'($urandom), 12'($urandom));
        end

        // Tick with enable to enter SHOW
        drive(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 12'h123);
        drive(1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 12'h456);
        drive(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 12'h789);

        // Addressing corners and box edges
        drive(1'b1, 1'b1, 112, 200, 1'b0, 1'b0, 12'h111);
        drive(1'b1, 1'b1, 511, 247, 1'b0, 1'b0, 12'h222);
        drive(1'b1, 1'b1, 111, 200, 1'b0, 1'b0, 12'h333);
        drive(1'b1, 1'b1, 512, 200, 1'b0, 1'b0, 12'h444);
        drive(1'b1, 1'b1, 112, 199, 1'b0, 1'b0, 12'h555);
        drive(1'b1, 1'b1, 112, 248, 1'b0, 1'b0, 12'h666);

        // Compositing: opaque then transparent ROM pixel, then blanked in-box pixel
        drive(1'b1, 1'b1, 117, 200, 1'b0, 1'b0, 12'h00F);
        drive(1'b1, 1'b1, 118, 200, 1'b0, 1'b0, 12'h00F);
        drive(1'b1, 1'b1, 117, 200, 1'b1, 1'b0, 12'h00F);

        // Blink: 70 frames of random pixels around the box
        for (int f = 0; f < 70; f++) begin
            for (int j = 0; j < 6; j++) rand_pixel(1'b1);
            drive(1'b1, 1'b1, $urandom_range(0, 1343), 780, 1'b1, 1'b1, 12'($urandom));
            drive(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 12'($urandom));
        end

        // Enable dropped mid-frame: text holds until the next tick
        drive(1'b1, 1'b1, 200, 210, 1'b0, 1'b0, 12'h0F0);
        for (int j = 0; j < 4; j++) drive(1'b1, 1'b0, 200 + j, 220, 1'b0, 1'b0, 12'h0F0);
        drive(1'b1, 1'b0, 0, 780, 1'b1, 1'b1, 12'h000);
        for (int j = 0; j < 4; j++) drive(1'b1, 1'b0, 200 + j, 220, 1'b0, 1'b0, 12'h0F0);

        // Random mix with occasional ticks, enable flips and a mid-frame reset
        begin
            bit en = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 199) == 0) en = ~en;
                if (i == 700 || i == 701) begin
                    drive(1'b0, en, $urandom_range(105, 520), $urandom_range(195, 252),
                          1'b0, 1'b0, 12'($urandom));
                end else if ($urandom_range(0, 9) == 0) begin
                    drive(1'b1, en, $urandom_range(0, 1343), 780, 1'b1, 1'b1, 12'($urandom));
                end else begin
                    rand_pixel(en);
                end
            end
        end

        // Drain with a bounded wait
        for (int i = 0; i < 20; i++) begin
            if (out_q.size() == 0 && addr_q.size() == 0) break;
            @(posedge clk);
        end
        total++;
        if (out_q.size() != 0 || addr_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending_out=%0d pending_addr=%0d want=0",
                     out_q.size(), addr_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
